// File: rtl/lookup_scan_ctrl.sv
// Scans an external cell store one read per cycle and reports the first matching cell.
// Define LOOKUP_SCAN_BEST_RANK_EN to scan every cell and report the highest-rank hit instead.
module lookup_scan_ctrl #(
  parameter int N_CELLS = 16,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              q_valid,
  output logic              q_ready,
  input  logic [DATA_W-1:0] q_index,
  input  logic [DATA_W-1:0] q_metadata,
  input  logic              q_is_meta,
  input  logic              abort,
  output logic              cell_rd_en,
  output logic [ADDR_W-1:0] cell_addr,
  input  logic              cell_elt_def,
  input  logic [DATA_W-1:0] cell_rank,
  input  logic [DATA_W-1:0] cell_low,
  input  logic [DATA_W-1:0] cell_high,
  input  logic [DATA_W-1:0] cell_index,
  input  logic [DATA_W-1:0] cell_value,
  output logic              r_valid,
  input  logic              r_ready,
  output logic              r_found,
  output logic [DATA_W-1:0] r_value,
  output logic [DATA_W-1:0] r_context,
  output logic [ADDR_W-1:0] r_addr
);
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, RESP} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_CELLS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              cmp_vld_q, cmp_vld_d;
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
  logic [DATA_W-1:0] qi_q, qi_d, qm_q, qm_d;
  logic              qs_q, qs_d;
  logic              rf_q, rf_d;
  logic [DATA_W-1:0] rv_q, rv_d, rc_q, rc_d;
  logic [ADDR_W-1:0] ra_q, ra_d;
  logic              match, hit, take;

  // Compare stage: read data belongs to the address issued on the previous cycle.
  assign match = cell_elt_def && (cell_index == qi_q) && (qm_q >= cell_low) &&
                 (qm_q <= cell_high) && qs_q;
  assign hit   = cmp_vld_q && match && (state_q == SCAN || state_q == DRAIN);
`ifdef LOOKUP_SCAN_BEST_RANK_EN
  assign take  = hit && (!rf_q || (cell_rank > rc_q));
`else
  assign take  = hit;
`endif

  assign cell_addr = cnt_q;
  assign r_found   = r_valid && rf_q;
  assign r_value   = r_valid ? rv_q : '0;
  assign r_context = r_valid ? rc_q : '0;
  assign r_addr    = r_valid ? ra_q : '0;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmp_addr_d = cnt_q;
    qi_d       = qi_q;
    qm_d       = qm_q;
    qs_d       = qs_q;
    rf_d       = rf_q;
    rv_d       = rv_q;
    rc_d       = rc_q;
    ra_d       = ra_q;
    q_ready    = 1'b0;
    cell_rd_en = 1'b0;
    r_valid    = 1'b0;
    if (take) begin
      rf_d = 1'b1;
      rv_d = cell_value;
      rc_d = cell_rank;
      ra_d = cmp_addr_q;
    end
    case (state_q)
      IDLE: begin
        q_ready = 1'b1;
        cnt_d   = '0;
        if (q_valid) begin
          qi_d    = q_index;
          qm_d    = q_metadata;
          qs_d    = q_is_meta;
          rf_d    = 1'b0;
          rv_d    = '0;
          rc_d    = '0;
          ra_d    = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        cell_rd_en = 1'b1;
`ifndef LOOKUP_SCAN_BEST_RANK_EN
        if (take) begin
          cell_rd_en = 1'b0;
          cnt_d      = '0;
          state_d    = RESP;
        end else
`endif
        if (cnt_q == LAST) state_d = DRAIN;
        else               cnt_d   = cnt_q + ADDR_W'(1);
      end
      DRAIN: begin
        cnt_d   = '0;
        state_d = RESP;
      end
      RESP: begin
        r_valid = 1'b1;
        if (r_ready) begin
          rf_d    = 1'b0;
          rv_d    = '0;
          rc_d    = '0;
          ra_d    = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort beats a same-cycle hit and drops any captured result.
    if (abort && (state_q == SCAN || state_q == DRAIN)) begin
      cell_rd_en = 1'b0;
      cnt_d      = '0;
      rf_d       = 1'b0;
      rv_d       = '0;
      rc_d       = '0;
      ra_d       = '0;
      state_d    = IDLE;
    end
    cmp_vld_d = cell_rd_en;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cmp_vld_q  <= 1'b0;
      cmp_addr_q <= '0;
      qi_q       <= '0;
      qm_q       <= '0;
      qs_q       <= 1'b0;
      rf_q       <= 1'b0;
      rv_q       <= '0;
      rc_q       <= '0;
      ra_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmp_vld_q  <= cmp_vld_d;
      cmp_addr_q <= cmp_addr_d;
      qi_q       <= qi_d;
      qm_q       <= qm_d;
      qs_q       <= qs_d;
      rf_q       <= rf_d;
      rv_q       <= rv_d;
      rc_q       <= rc_d;
      ra_q       <= ra_d;
    end
  end
endmodule

// File: doc/lookup_scan_ctrl.md
Name: lookup_scan_ctrl

Overview:
- Sequencer that shares one lookup comparison datapath across an external cell store of N_CELLS entries.
- Accepts a query (index, metadata, isMetadata) over a valid/ready handshake and issues one cell read per cycle.
- Compares each returned cell against the query and returns the value and rank of the first hit, or a miss.
- Sits between the host/query logic and the cell RAM that holds arrDef/array_code/eltDef/rank/low/high/index/value records.

Parameters:
- N_CELLS, 16, number of cells scanned per query (2..2**ADDR_W)
- ADDR_W, 4, cell address width
- DATA_W, 8, width of index/value/rank/low/high/metadata fields

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- q_valid  in  1  query valid
- q_ready  out  1  controller idle, query accepted when q_valid&&q_ready
- q_index  in  DATA_W  query index (new_index)
- q_metadata  in  DATA_W  query metadata
- q_is_meta  in  1  metadata qualifier; 0 forces a miss
- abort  in  1  cancel the scan in progress
- cell_rd_en  out  1  cell read strobe
- cell_addr  out  ADDR_W  cell read address
- cell_elt_def  in  1  cell eltDef, valid 1 cycle after cell_rd_en
- cell_rank  in  DATA_W  cell rank
- cell_low  in  DATA_W  cell low bound
- cell_high  in  DATA_W  cell high bound
- cell_index  in  DATA_W  cell index
- cell_value  in  DATA_W  cell value
- r_valid  out  1  response valid
- r_ready  in  1  response consumer ready
- r_found  out  1  1 = hit
- r_value  out  DATA_W  hit cell value (0 on miss)
- r_context  out  DATA_W  hit cell rank (0 on miss)
- r_addr  out  ADDR_W  hit cell address (0 on miss)

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE. q_ready=1; cell_rd_en=0; cell_addr=0; r_valid=0; r_found=0; r_value=0; r_context=0; r_addr=0. Reset overrides any scan or pending response; no response is produced for an interrupted query.
- Query is latched on acceptance (q_valid&&q_ready). Later changes on q_* inputs have no effect.
- Hit rule, evaluated on the cycle the read data returns: cell_elt_def && cell_index==q_index && q_metadata>=cell_low && q_metadata<=cell_high && q_is_meta. Unsigned compares; bounds are inclusive.
- States:
  - IDLE: q_ready=1. On accept → SCAN, addr counter=0.
  - SCAN: cell_rd_en=1, cell_addr=counter, counter+1 each cycle. The compare stage runs one cycle behind.
    - On a hit → RESP: capture value/rank/addr, drop cell_rd_en that cycle, discard the in-flight read.
    - After address N_CELLS-1 is issued → DRAIN: 1 cycle, compare the last cell.
  - DRAIN: hit → RESP with captured data; else → RESP with r_found=0.
  - RESP: r_valid=1, outputs held stable until r_ready=1. On r_valid&&r_ready → IDLE; r_* fields return to 0.
- Latency (accept at cycle 0):
  - Address k is issued at cycle 1+k and compared at cycle 2+k.
  - Hit at k: r_valid from cycle 3+k.
  - Miss: r_valid from cycle N_CELLS+2.
- q_ready=0 in SCAN/DRAIN/RESP. There is no query queueing.
- abort=1 in SCAN or DRAIN: → IDLE next cycle, cell_rd_en=0, no response. abort is ignored in IDLE and RESP.
- Simultaneous hit and abort in the same cycle: abort wins.
- Counter never wraps. Addresses ≥ N_CELLS are never issued.
- If multiple cells hit, the lowest address wins (default build).

Optional Feature:
- Macro: LOOKUP_SCAN_BEST_RANK_EN.
- Defined:
  - A hit does not stop the scan; all N_CELLS cells are read.
  - The hit with the strictly greatest rank is kept; ties keep the lower address.
  - r_valid always at cycle N_CELLS+2.
- Undefined: first-hit early termination as above.

Test Plan:
- Default N_CELLS=16; cell 5 = {eltDef=1, index=0x22, low=0x10, high=0x20, value=0xAB, rank=0x07}; others eltDef=0. Query index=0x22, meta=0x15, is_meta=1 → r_valid at cycle 8, r_found=1, r_value=0xAB, r_context=0x07, r_addr=5; cell_addr never exceeds 6.
- Same cells, meta=0x20 (inclusive high) → hit at cycle 8. meta=0x21 → r_found=0 at cycle 18 with value/context/addr=0. is_meta=0 → miss.
- Cells 3 (rank 2) and 9 (rank 9) both match:
  - default build → r_addr=3, r_context=2 at cycle 6.
  - LOOKUP_SCAN_BEST_RANK_EN → r_addr=9, r_context=9 at cycle 18.
- Hold r_ready=0 for 5 cycles after r_valid → outputs stable and q_ready=0 throughout. Pulse q_valid during this window → not accepted.
- Pulse abort at cycle 4 of a scan → cell_rd_en=0 from cycle 5, q_ready=1, r_valid never asserts. Next query completes normally.
- Assert rst_n=0 for 1 cycle mid-SCAN and separately during RESP → all outputs at reset values next cycle, no stale response afterwards.
